// File: rtl/timer_pkg.sv
// +----------------------------------------------------------------------+
// | timer_pkg : state encodings and helpers shared by the timer blocks   |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int c_min_nreq = 2;
  localparam int c_max_nreq = 8;

  // Round-robin successor of an index in a ring of n slots.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at i_ptr         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  int            w_j;
  logic [IW-1:0] w_sel;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    w_sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      w_sel = IW'(w_j);
      if (i_req[w_sel]) begin
        o_grant        = '0;
        o_grant[w_sel] = 1'b1;
        o_idx          = w_sel;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_sched.sv
// +----------------------------------------------------------------------+
// | timer_sched : one shared timeout counter granted round-robin         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module timer_sched
  import timer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_len,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_busy,
  output logic [NREQ-1:0]       o_done
);

  localparam int c_iw = $clog2(NREQ);

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_count, w_count_nxt;
  logic [c_iw-1:0]   r_ptr, w_ptr_nxt;
  logic [c_iw-1:0]   r_owner, w_owner_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic [NREQ-1:0]   r_done, w_done_nxt;
  logic              r_busy, w_busy_nxt;

  logic [NREQ-1:0]   w_arb_grant;
  logic [c_iw-1:0]   w_arb_idx;
  logic              w_arb_valid;
  logic [WIDTH-1:0]  w_len_sel;
  logic [c_iw-1:0]   w_owner_succ;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (c_iw)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_len_sel    = i_len[int'(w_arb_idx)*WIDTH +: WIDTH];
  assign w_owner_succ = c_iw'(next_idx(int'(r_owner), NREQ));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = w_len_sel;
          w_owner_nxt = w_arb_idx;
          w_grant_nxt = w_arb_grant;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        // A dropped request wins over an expiry on the same edge.
        if (!i_req[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = w_owner_succ;
        end else if (r_count == '0) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = r_grant;
        end else if (i_en) begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = w_owner_succ;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_done  = r_done;
  assign o_busy  = r_busy;

`ifdef FORMAL
  initial begin
    r_state = ST_IDLE;
    r_count = '0;
    r_ptr   = '0;
    r_owner = '0;
    r_grant = '0;
    r_done  = '0;
    r_busy  = 1'b0;
  end

  always_comb begin
    a_grant_onehot0 : assert ($onehot0(r_grant));
    a_done_onehot0  : assert ($onehot0(r_done));
    a_done_owner    : assert ((r_done & ~r_grant) == '0);
  end

  a_no_wrap : assert property (@(posedge i_clk) disable iff (i_rst)
    (r_state == ST_RUN && r_count == '0) |=> (r_count == '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_sched.sv
// +----------------------------------------------------------------------+
// | tb_timer_sched : vector table + scoreboard bench for timer_sched     |
// | Revision       : 1.0 - initial release                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_timer_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
  } out_t;

  typedef struct {
    bit                    do_rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  en;
    out_t                  exp;
    string                 name;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   tests = 0;
  int   fails = 0;

  timer_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .i_req   (req),
    .i_len   (len),
    .o_grant (grant),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [NREQ*WIDTH-1:0] lens(input int l0, input int l1,
                                                 input int l2, input int l3);
    return {WIDTH'(l3), WIDTH'(l2), WIDTH'(l1), WIDTH'(l0)};
  endfunction

  function automatic void add(input bit r, input logic [NREQ-1:0] q,
                              input logic [NREQ*WIDTH-1:0] l, input logic e,
                              input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                              input logic b, input string n);
    vec_t t;
    t.do_rst = r;
    t.req    = q;
    t.len    = l;
    t.en     = e;
    t.exp    = '{grant: g, done: d, busy: b};
    t.name   = n;
    vecs.push_back(t);
  endfunction

  task automatic check_out(input string name);
    out_t e;
    out_t a;
    a = '{grant: grant, done: done, busy: busy};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got grant=%b done=%b busy=%b, expected grant=%b done=%b busy=%b",
                 name, a.grant, a.done, a.busy, e.grant, e.done, e.busy);
      end
    end
  endtask

  // Reset is asserted between edges, so a clear here proves it is asynchronous.
  task automatic apply_reset(input string name);
    rst = 1'b1;
    req = '0;
    en  = 1'b0;
    #2;
    sb.push_back('0);
    check_out(name);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic [NREQ-1:0] q, input logic [NREQ*WIDTH-1:0] l,
                      input logic e, input out_t exp, input string name);
    req = q;
    len = l;
    en  = e;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] l;
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    len = '0;

    // single requester, length 3: done four edges after the grant
    l = lens(3, 0, 0, 0);
    add(1, 4'b0001, l, 1, 4'b0001, 4'b0000, 1, "a_grant");
    add(0, 4'b0001, l, 1, 4'b0001, 4'b0000, 1, "a_run2");
    add(0, 4'b0001, l, 1, 4'b0001, 4'b0000, 1, "a_run1");
    add(0, 4'b0001, l, 1, 4'b0001, 4'b0000, 1, "a_run0");
    add(0, 4'b0001, l, 1, 4'b0001, 4'b0001, 1, "a_done");
    add(0, 4'b0000, l, 1, 4'b0000, 4'b0000, 0, "a_idle");
    add(0, 4'b0000, l, 1, 4'b0000, 4'b0000, 0, "a_idle2");

    // all four requesting with zero length, each drops on its own done
    l = lens(0, 0, 0, 0);
    add(1, 4'b1111, l, 1, 4'b0001, 4'b0000, 1, "b_g0");
    add(0, 4'b1111, l, 1, 4'b0001, 4'b0001, 1, "b_d0");
    add(0, 4'b1110, l, 1, 4'b0000, 4'b0000, 0, "b_i0");
    add(0, 4'b1110, l, 1, 4'b0010, 4'b0000, 1, "b_g1");
    add(0, 4'b1110, l, 1, 4'b0010, 4'b0010, 1, "b_d1");
    add(0, 4'b1100, l, 1, 4'b0000, 4'b0000, 0, "b_i1");
    add(0, 4'b1100, l, 1, 4'b0100, 4'b0000, 1, "b_g2");
    add(0, 4'b1100, l, 1, 4'b0100, 4'b0100, 1, "b_d2");
    add(0, 4'b1000, l, 1, 4'b0000, 4'b0000, 0, "b_i2");
    add(0, 4'b1000, l, 1, 4'b1000, 4'b0000, 1, "b_g3");
    add(0, 4'b1000, l, 1, 4'b1000, 4'b1000, 1, "b_d3");
    add(0, 4'b0000, l, 1, 4'b0000, 4'b0000, 0, "b_i3");

    // length 5 with enable toggling: ten RUN edges before done
    l = lens(5, 0, 0, 0);
    add(1, 4'b0001, l, 0, 4'b0001, 4'b0000, 1, "c_grant");
    for (int k = 0; k < 9; k++)
      add(0, 4'b0001, l, logic'((k % 2) == 0), 4'b0001, 4'b0000, 1, $sformatf("c_run%0d", k));
    add(0, 4'b0001, l, 0, 4'b0001, 4'b0001, 1, "c_done");
    add(0, 4'b0000, l, 0, 4'b0000, 4'b0000, 0, "c_idle");

    // owner 2 aborts; pointer moves to 3 so requester 3 beats requester 0
    l = lens(0, 0, 10, 2);
    add(1, 4'b1100, l, 1, 4'b0100, 4'b0000, 1, "d_grant2");
    add(0, 4'b1100, l, 1, 4'b0100, 4'b0000, 1, "d_run1");
    add(0, 4'b1100, l, 1, 4'b0100, 4'b0000, 1, "d_run2");
    add(0, 4'b1100, l, 1, 4'b0100, 4'b0000, 1, "d_run3");
    add(0, 4'b1001, l, 1, 4'b0000, 4'b0000, 0, "d_abort");
    add(0, 4'b1001, l, 1, 4'b1000, 4'b0000, 1, "d_grant3");
    add(0, 4'b1001, l, 1, 4'b1000, 4'b0000, 1, "d_run_a");
    add(0, 4'b1001, l, 1, 4'b1000, 4'b0000, 1, "d_run_b");
    add(0, 4'b1001, l, 1, 4'b1000, 4'b1000, 1, "d_done3");
    add(0, 4'b0001, l, 1, 4'b0000, 4'b0000, 0, "d_idle");
    add(0, 4'b0001, l, 1, 4'b0001, 4'b0000, 1, "d_grant0");
    add(0, 4'b0001, l, 1, 4'b0001, 4'b0001, 1, "d_done0");
    add(0, 4'b0000, l, 1, 4'b0000, 4'b0000, 0, "d_idle2");

    // length changes after the grant edge must not matter
    add(1, 4'b0010, lens(0, 4, 0, 0), 1, 4'b0010, 4'b0000, 1, "e_grant");
    for (int k = 0; k < 4; k++)
      add(0, 4'b0010, lens(0, 200, 0, 0), 1, 4'b0010, 4'b0000, 1, $sformatf("e_run%0d", k));
    add(0, 4'b0010, lens(0, 200, 0, 0), 1, 4'b0010, 4'b0010, 1, "e_done");
    add(0, 4'b0000, lens(0, 200, 0, 0), 1, 4'b0000, 4'b0000, 0, "e_idle");

    // zero length expires with enable low; held request is granted again
    l = lens(0, 0, 0, 0);
    add(1, 4'b0001, l, 0, 4'b0001, 4'b0000, 1, "f_grant");
    add(0, 4'b0001, l, 0, 4'b0001, 4'b0001, 1, "f_done");
    add(0, 4'b0001, l, 0, 4'b0000, 4'b0000, 0, "f_idle");
    add(0, 4'b0001, l, 0, 4'b0001, 4'b0000, 1, "f_regrant");
    add(0, 4'b0001, l, 0, 4'b0001, 4'b0001, 1, "f_redone");
    add(0, 4'b0000, l, 0, 4'b0000, 4'b0000, 0, "f_idle2");

    // abort at count zero beats expiry; pointer then favours requester 1
    add(1, 4'b0001, l, 1, 4'b0001, 4'b0000, 1, "h_grant");
    add(0, 4'b0000, l, 1, 4'b0000, 4'b0000, 0, "h_abort");
    add(0, 4'b0011, l, 1, 4'b0010, 4'b0000, 1, "h_grant1");
    add(0, 4'b0011, l, 1, 4'b0010, 4'b0010, 1, "h_done1");
    add(0, 4'b0000, l, 1, 4'b0000, 4'b0000, 0, "h_idle");

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) apply_reset({vecs[i].name, "_rst"});
      step(vecs[i].req, vecs[i].len, vecs[i].en, vecs[i].exp, vecs[i].name);
    end

    // asynchronous reset in the middle of RUN, then arbitration restarts at 0
    apply_reset("g_rst");
    l = lens(50, 7, 0, 0);
    step(4'b0001, l, 1, '{grant: 4'b0001, done: 4'b0000, busy: 1'b1}, "g_grant");
    step(4'b0001, l, 1, '{grant: 4'b0001, done: 4'b0000, busy: 1'b1}, "g_run");
    step(4'b0001, l, 1, '{grant: 4'b0001, done: 4'b0000, busy: 1'b1}, "g_run2");
    #3;
    rst = 1'b1;
    #1;
    sb.push_back('0);
    check_out("g_async_clear");
    #1;
    rst = 1'b0;
    req = '0;
    step(4'b1010, l, 1, '{grant: 4'b0010, done: 4'b0000, busy: 1'b1}, "g_post_rst_grant");
    step(4'b1010, l, 1, '{grant: 4'b0010, done: 4'b0000, busy: 1'b1}, "g_post_rst_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one timeout counter (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, bit width of each requested timeout length.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_en  input  1  tick enable; the counter decrements only on edges where i_en=1.
REQ-006 SHALL have port i_req  input  NREQ  level request per requester; held until o_done or abandoned.
REQ-007 SHALL have port i_len  input  NREQ*WIDTH  timeout length per requester; slice k = bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port o_grant  output  NREQ  one-hot owner of the counter; all-zero when idle.
REQ-009 SHALL have port o_busy  output  1  high in RUN and DONE.
REQ-010 SHALL have port o_done  output  NREQ  one-cycle timeout-expired pulse to the owner.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE; all outputs registered.
REQ-012 IDLE: on an edge with any i_req bit set, SHALL select winner by round-robin from pointer ptr, load count = i_len[winner], set o_grant one-hot, and enter RUN.
REQ-013 Round-robin SHALL search ptr, ptr+1, ..., wrapping modulo NREQ; first set bit wins.
REQ-014 i_len SHALL be sampled only at the grant edge; later changes SHALL NOT affect the running timeout.
REQ-015 RUN: if i_req[owner]=0 at an edge, SHALL abort: IDLE, o_grant=0, no o_done, ptr=owner+1 mod NREQ.
REQ-016 RUN, owner still requesting: if count=0, SHALL enter DONE and assert o_done[owner]; else if i_en=1, count SHALL decrement by 1; else hold.
REQ-017 Abort SHALL take priority over expiry on the same edge.
REQ-018 DONE: SHALL last exactly one cycle, then IDLE with o_grant=0, o_done=0, ptr=owner+1 mod NREQ.
REQ-019 With i_en held high, o_done SHALL rise L+1 cycles after the grant edge for length L; L=0 gives o_done on the next edge.
REQ-020 Count SHALL never wrap below zero; WIDTH-bit unsigned arithmetic.
REQ-021 A request still high when IDLE is re-entered SHALL be treated as a new request and arbitrated normally.
REQ-022 Non-owner request changes during RUN/DONE SHALL have no effect until IDLE.
REQ-023 At most one o_grant bit and at most one o_done bit SHALL be set at any time; o_done[k] only when o_grant[k].

Reset
REQ-024 i_rst high SHALL immediately force IDLE, count=0, ptr=0, o_grant=0, o_done=0, o_busy=0, regardless of i_clk.
REQ-025 Reset mid-RUN SHALL discard the timeout with no o_done; the first grant after reset release SHALL follow REQ-012 with ptr=0.
REQ-026 All registers SHALL also carry matching initial values for simulation and formal.

Structure
REQ-027 FSM state encodings SHALL reside in a shared package (timer_pkg) alongside the state constants used by the counter block.
REQ-028 SHALL instantiate one sub-module, rr_arbiter (NREQ requests plus pointer in, one-hot grant and index out, combinational); counter and FSM stay in timer_sched.
REQ-029 Implementation SHALL include FORMAL-guarded assertions for REQ-023 and REQ-020.

Verification
REQ-030 Reset, i_req=4'b0001, i_len[0]=3, i_en=1 -> o_grant=0001 next edge; o_done=0001 for one cycle 4 cycles later; then o_grant=0.
REQ-031 i_req=4'b1111, all lengths 0, requests dropped on own o_done -> grants in order 0001,0010,0100,1000, each o_done one cycle, no gaps or repeats.
REQ-032 Owner 0, len=5, i_en toggled 1/0 each cycle -> o_done after 10 cycles of RUN; count stays unchanged on i_en=0 edges.
REQ-033 Owner 2 running, len=10, drop i_req[2] after 3 cycles while i_req[3]=1 -> no o_done; IDLE then o_grant=1000.
REQ-034 i_rst pulsed asynchronously mid-RUN (between edges) -> o_grant, o_busy, o_done go 0 immediately; after release i_req=1010 -> o_grant=0010.
REQ-035 i_len[1] changed from 4 to 200 one cycle after grant -> o_done still at 5 cycles (sampled value 4).
